// File: rtl/count_bcd_display.sv
// count_bcd_display: turns the 8-bit counter value into three BCD digits with a
// sequential shift-add-3 engine. It then drives a time-multiplexed
// common-anode 7-segment display. Only three of the four digits are used.
// Optional macro LEADING_ZERO_BLANK_EN: when defined, leading zero digits
// (hundreds, and tens when hundreds is also zero) are kept dark.
module count_bcd_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DIN,
  output logic        BUSY,
  output logic [11:0] BCD,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [19:0] work_q, work_d;
  logic [3:0]  iter_q, iter_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  last_val_q, last_val_d;
  logic [11:0] bcd_q, bcd_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  digit_idx_q, digit_idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic [19:0] work_adj;
  logic [3:0]  digit_nib;
  logic        blank_hund;
  logic        blank_tens;
  logic        digit_blank;

  // 7-segment pattern for one BCD nibble, gfedcba, active-low
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift
  always_comb begin
    work_adj = work_q;
    if (work_q[11:8] >= 4'd5)  work_adj[11:8]  = work_q[11:8]  + 4'd3;
    if (work_q[15:12] >= 4'd5) work_adj[15:12] = work_q[15:12] + 4'd3;
    if (work_q[19:16] >= 4'd5) work_adj[19:16] = work_q[19:16] + 4'd3;
  end

  // Conversion FSM next state: capture on a new value, 8 shift steps, then publish
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    work_d     = work_q;
    iter_d     = iter_q;
    cap_d      = cap_q;
    last_val_d = last_val_q;
    bcd_d      = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (DIN != last_val_q) begin
          cap_d   = DIN;
          work_d  = {12'h000, DIN};
          iter_d  = 4'd0;
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        work_d = {work_adj[18:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd7) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d      = work_q[19:8];
        last_val_d = cap_q;
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Leading-zero blanking decisions, computed from the currently shown value
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_hund = (bcd_q[11:8] == 4'd0);
    blank_tens = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`else
    blank_hund = 1'b0;
    blank_tens = 1'b0;
`endif
  end

  // Scan timing and the segment/anode pattern for the digit currently selected
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 16'd1;
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = 16'd0;
      digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
    end

    digit_nib   = 4'hF;
    digit_blank = 1'b1;
    an_d        = 4'b1111;
    case (digit_idx_q)
      2'd0: begin
        digit_nib   = bcd_q[3:0];
        digit_blank = 1'b0;
        an_d        = 4'b1110;
      end
      2'd1: begin
        digit_nib   = bcd_q[7:4];
        digit_blank = blank_tens;
        an_d        = 4'b1101;
      end
      2'd2: begin
        digit_nib   = bcd_q[11:8];
        digit_blank = blank_hund;
        an_d        = 4'b1011;
      end
      default: begin
        digit_nib   = 4'hF;
        digit_blank = 1'b1;
        an_d        = 4'b1111;
      end
    endcase

    if (digit_blank) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end else begin
      seg_d = seg_decode(digit_nib);
    end
  end

  // All state registers, with a synchronous reset that also aborts a conversion
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      work_q      <= 20'h00000;
      iter_q      <= 4'd0;
      cap_q       <= 8'd0;
      last_val_q  <= 8'd0;
      bcd_q       <= 12'h000;
      scan_cnt_q  <= 16'd0;
      digit_idx_q <= 2'd0;
      seg_q       <= 7'b1111111;
      an_q        <= 4'b1111;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      work_q      <= work_d;
      iter_q      <= iter_d;
      cap_q       <= cap_d;
      last_val_q  <= last_val_d;
      bcd_q       <= bcd_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign BUSY = busy_q;
  assign BCD  = bcd_q;
  assign SEG  = seg_q;
  assign AN   = an_q;
  assign DP   = 1'b1;

endmodule

// File: tb/tb_count_bcd_display.sv
// Testbench for count_bcd_display (SCAN_DIV=4). Expected BCD values are queued
// when a conversion is started and compared when BUSY drops. Display
// expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_count_bcd_display;

  logic        CLK;
  logic        RST;
  logic [7:0]  DIN;
  logic        BUSY;
  logic [11:0] BCD;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  count_bcd_display #(.SCAN_DIV(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .DIN (DIN),
    .BUSY(BUSY),
    .BCD (BCD),
    .SEG (SEG),
    .AN  (AN),
    .DP  (DP)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {AN, SEG} for a slot (0=ones, 1=tens, 2=hundreds)
  function automatic logic [10:0] disp_expect(input int slot, input logic [11:0] b);
    logic blank;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 2) blank = (b[11:8] == 4'd0);
    if (slot == 1) blank = (b[11:8] == 4'd0) && (b[7:4] == 4'd0);
`endif
    if (blank) return {4'b1111, 7'b1111111};
    case (slot)
      0: return {4'b1110, seg_code(b[3:0])};
      1: return {4'b1101, seg_code(b[7:4])};
      default: return {4'b1011, seg_code(b[11:8])};
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DIN = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (SEG !== 7'b1111111 || AN !== 4'b1111) begin
        errors++;
        $display("[TB] FAIL reset_display: SEG=%b AN=%b expected SEG=1111111 AN=1111", SEG, AN);
      end
    end
    checks++;
    if (BUSY !== 1'b0 || BCD !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_state: BUSY=%b BCD=%h expected BUSY=0 BCD=000", BUSY, BCD);
    end
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (BUSY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_no_conv: cycle %0d BUSY=%b expected 0", i, BUSY);
      end
    end
    checks++;
    if (BCD !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_bcd: BCD=%h expected 000", BCD);
    end
  endtask

  task automatic test_convert_255();
    logic [11:0] exp;
    DIN = 8'd255;
    exp_q.push_back(to_bcd(255));
    for (int e = 0; e < 9; e++) begin
      tick();
      checks++;
      if (BUSY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL busy_255: edge k+%0d BUSY=%b expected 1", e, BUSY);
      end
    end
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (BUSY !== 1'b0 || BCD !== exp) begin
      errors++;
      $display("[TB] FAIL result_255: BUSY=%b BCD=%h expected BUSY=0 BCD=%h", BUSY, BCD, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    DIN = 8'd128;
    exp_q.push_back(to_bcd(128));
    tick();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_start: BUSY=%b expected 1", BUSY);
    end
    repeat (3) tick();
    DIN = 8'd7;
    exp_q.push_back(to_bcd(7));
    repeat (5) tick();
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (BUSY !== 1'b0 || BCD !== exp) begin
      errors++;
      $display("[TB] FAIL b2b_first: BUSY=%b BCD=%h expected BUSY=0 BCD=%h", BUSY, BCD, exp);
    end
    tick();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_restart: BUSY=%b expected 1 at k+10", BUSY);
    end
    repeat (8) tick();
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (BUSY !== 1'b0 || BCD !== exp) begin
      errors++;
      $display("[TB] FAIL b2b_second: BUSY=%b BCD=%h expected BUSY=0 BCD=%h", BUSY, BCD, exp);
    end
  endtask

  task automatic test_scan(input int value);
    logic [11:0] exp;
    logic [10:0] want;
    logic [3:0]  prev_an;
    bit          done;
    bit          found;
    DIN = 8'(value);
    exp_q.push_back(to_bcd(value));
    done = 1'b0;
    for (int i = 0; i < 15 && !done; i++) begin
      tick();
      if (i > 0 && BUSY === 1'b0) done = 1'b1;
    end
    exp = exp_q.pop_front();
    checks++;
    if (!done || BCD !== exp) begin
      errors++;
      $display("[TB] FAIL scan_conv_%0d: done=%0d BCD=%h expected BCD=%h", value, done, BCD, exp);
    end
    prev_an = AN;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick();
      if (AN === 4'b1110 && prev_an !== 4'b1110) found = 1'b1;
      else prev_an = AN;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL scan_align_%0d: AN=%b never entered ones slot", value, AN);
    end else begin
      for (int j = 0; j < 16; j++) begin
        if (j > 0) tick();
        want = disp_expect((j / 4) % 3, exp);
        checks++;
        if (AN !== want[10:7] || SEG !== want[6:0]) begin
          errors++;
          $display("[TB] FAIL scan_%0d_c%0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                   value, j, AN, SEG, want[10:7], want[6:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    DIN = 8'd200;
    tick();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_start: BUSY=%b expected 1", BUSY);
    end
    repeat (4) tick();
    RST = 1'b1;
    tick();
    checks++;
    if (BUSY !== 1'b0 || BCD !== 12'h000 || AN !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL mid_reset: BUSY=%b BCD=%h AN=%b expected BUSY=0 BCD=000 AN=1111",
               BUSY, BCD, AN);
    end
    RST = 1'b0;
    exp_q.push_back(to_bcd(200));
    tick();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_recapture: BUSY=%b expected 1", BUSY);
    end
    repeat (8) tick();
    checks++;
    if (BUSY !== 1'b1 || BCD !== 12'h000) begin
      errors++;
      $display("[TB] FAIL mid_partial: BUSY=%b BCD=%h expected BUSY=1 BCD=000", BUSY, BCD);
    end
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (BUSY !== 1'b0 || BCD !== exp) begin
      errors++;
      $display("[TB] FAIL mid_result: BUSY=%b BCD=%h expected BUSY=0 BCD=%h", BUSY, BCD, exp);
    end
    checks++;
    if (exp_q.size() != 0 || DP !== 1'b1) begin
      errors++;
      $display("[TB] FAIL final_state: queue=%0d DP=%b expected queue=0 DP=1", exp_q.size(), DP);
    end
  endtask

  // Runs every scenario in order and prints the summary
  initial begin
    RST = 1'b1;
    DIN = 8'd0;
    test_reset();
    test_convert_255();
    test_back_to_back();
    test_scan(137);
    test_scan(7);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
